// File: rtl/axi_dma_wr_engine.sv
// Write-side DMA engine: splits one block-write request into AXI4 INCR bursts,
// prefetches words from the output buffer into a 2-entry FIFO and drives AW/W/B.
module axi_dma_wr_engine #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BIT_TRANS    = 18,
    parameter int MAX_BURST    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_ctrl_write,
    input  logic [AXI_WIDTH_AD-1:0]   i_write_addr,
    input  logic [BIT_TRANS-1:0]      i_num_trans,
    output logic                      o_indata_req_wr,
    input  logic [AXI_WIDTH_DA-1:0]   i_indata_wr,
    output logic                      o_write_done,
    output logic                      o_busy,
    output logic                      o_err,
    output logic [AXI_WIDTH_AD-1:0]   m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_WIDTH_DA-1:0]   m_axi_wdata,
    output logic [AXI_WIDTH_DA/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam logic [2:0] AWSIZE = 3'($clog2(AXI_WIDTH_DA / 8));

    typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;

    state_t                  r_state;
    logic [AXI_WIDTH_AD-1:0] r_addr;
    logic [BIT_TRANS-1:0]    r_remaining;
    logic [7:0]              r_awlen;
    logic [8:0]              r_req_cnt;
    logic [7:0]              r_beat_cnt;
    logic                    r_awvalid;
    logic                    r_bready;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_err;

    logic [AXI_WIDTH_DA-1:0] r_fifo [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_fifo_cnt;
    logic                    r_inflight;

    logic [8:0]              w_burst;
    logic [BIT_TRANS-1:0]    w_rem_next;
    logic [8:0]              w_first_burst;
    logic [8:0]              w_next_burst;
    logic                    w_wvalid;
    logic                    w_pop;
    logic                    w_wlast;
    logic [1:0]              w_level;
    logic                    w_req;

    function automatic logic [8:0] f_burst(input logic [BIT_TRANS-1:0] rem);
        if (rem >= BIT_TRANS'(MAX_BURST)) f_burst = 9'(MAX_BURST);
        else                              f_burst = rem[8:0];
    endfunction

    assign w_burst       = {1'b0, r_awlen} + 9'd1;
    assign w_rem_next    = r_remaining - BIT_TRANS'(w_burst);
    assign w_first_burst = f_burst(i_num_trans);
    assign w_next_burst  = f_burst(w_rem_next);

    assign w_wvalid = (r_state == ST_W) && (r_fifo_cnt != 2'd0);
    assign w_pop    = w_wvalid && m_axi_wready;
    assign w_wlast  = w_wvalid && (r_beat_cnt == r_awlen);

    // A word leaving the FIFO this cycle frees a slot, which keeps W at one beat per cycle.
    assign w_level = r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_req   = ((r_state == ST_AW) || (r_state == ST_W)) &&
                     (r_req_cnt < w_burst) && (w_level < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_awlen     <= '0;
            r_req_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_req) r_req_cnt <= r_req_cnt + 9'd1;
            case (r_state)
                ST_IDLE: begin
                    if (i_ctrl_write) begin
                        r_addr      <= i_write_addr;
                        r_remaining <= i_num_trans;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (i_num_trans == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_AW;
                            r_awvalid  <= 1'b1;
                            r_awlen    <= 8'(w_first_burst - 9'd1);
                            r_req_cnt  <= '0;
                            r_beat_cnt <= '0;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_wlast) begin
                            r_state  <= ST_B;
                            r_bready <= 1'b1;
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_remaining <= w_rem_next;
                        r_addr      <= r_addr + (AXI_WIDTH_AD'(w_burst) << AWSIZE);
                        if (m_axi_bresp != 2'b00) r_err <= 1'b1;
                        if (w_rem_next != '0) begin
                            r_state    <= ST_AW;
                            r_awvalid  <= 1'b1;
                            r_awlen    <= 8'(w_next_burst - 9'd1);
                            r_req_cnt  <= '0;
                            r_beat_cnt <= '0;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // An empty request arrives with r_done low and spends one extra cycle here.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= i_indata_wr;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({r_inflight, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign o_indata_req_wr = w_req;
    assign o_write_done    = r_done;
    assign o_busy          = r_busy;
    assign o_err           = r_err;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = r_awvalid ? AWSIZE : 3'd0;
    assign m_axi_awburst = r_awvalid ? 2'b01 : 2'b00;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_wdata  = r_fifo[r_rd_ptr];
    assign m_axi_wstrb  = w_wvalid ? '1 : '0;
    assign m_axi_wlast  = w_wlast;
    assign m_axi_wvalid = w_wvalid;
    assign m_axi_bready = r_bready;

endmodule

// File: tb/tb_axi_dma_wr_engine.sv
// Directed bench for axi_dma_wr_engine: buffer/AXI slave responders, a negedge
// monitor that logs handshakes, and one linear sequence of checked steps.
module tb_axi_dma_wr_engine;

    logic        clk;
    logic        rst;
    logic        i_ctrl_write;
    logic [31:0] i_write_addr;
    logic [17:0] i_num_trans;
    logic        o_indata_req_wr;
    logic [31:0] i_indata_wr;
    logic        o_write_done;
    logic        o_busy;
    logic        o_err;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    axi_dma_wr_engine #(
        .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .BIT_TRANS(18), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_ctrl_write(i_ctrl_write), .i_write_addr(i_write_addr), .i_num_trans(i_num_trans),
        .o_indata_req_wr(o_indata_req_wr), .i_indata_wr(i_indata_wr),
        .o_write_done(o_write_done), .o_busy(o_busy), .o_err(o_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // responder modes, written only by the stimulus block
    bit wready_rand;
    int aw_delay;
    int berr_at;

    // responder state
    int cyc;
    int rd_idx;
    int aw_cnt;
    logic req_latched;

    // monitor logs
    logic [31:0] w_data [512];
    logic        w_last [512];
    int          w_cyc  [512];
    int          w_n;
    logic [31:0] aw_addr_a [64];
    logic [7:0]  aw_len_a  [64];
    int          aw_n;
    int          b_count, b_cyc, done_cnt, done_cyc;
    logic        err_at_done;
    int          aw_unstable, attr_bad, any_activity;
    int          req_total, pop_total, max_pend;
    logic        aw_hold;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;

    int n_checks;
    int n_errors;

    logic [31:0] exp_q[$];

    // Buffer and AXI slave responder; drives its inputs 1 time unit after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (req_latched) begin
            i_indata_wr = 32'hA000_0000 + 32'(rd_idx);
            rd_idx = rd_idx + 1;
        end
        if (m_axi_awvalid) begin
            m_axi_awready = (aw_cnt >= aw_delay);
            aw_cnt = aw_cnt + 1;
        end else begin
            m_axi_awready = 1'b0;
            aw_cnt = 0;
        end
        m_axi_wready = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_bvalid = m_axi_bready;
        m_axi_bresp  = (m_axi_bready && b_count == berr_at) ? 2'b10 : 2'b00;
    end

    // Monitor: samples mid-cycle what the next rising edge will see.
    always @(negedge clk) begin
        req_latched = !rst && o_indata_req_wr;
        if (rst) begin
            aw_hold = 1'b0;
        end else begin
            if (o_indata_req_wr) req_total = req_total + 1;
            if (m_axi_awvalid && aw_hold &&
                (m_axi_awaddr !== hold_addr || m_axi_awlen !== hold_len))
                aw_unstable = aw_unstable + 1;
            aw_hold   = m_axi_awvalid && !m_axi_awready;
            hold_addr = m_axi_awaddr;
            hold_len  = m_axi_awlen;
            if (m_axi_awvalid && m_axi_awready && aw_n < 64) begin
                aw_addr_a[aw_n] = m_axi_awaddr;
                aw_len_a[aw_n]  = m_axi_awlen;
                if (m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01) attr_bad = attr_bad + 1;
                aw_n = aw_n + 1;
            end
            if (m_axi_wvalid && m_axi_wready && w_n < 512) begin
                w_data[w_n] = m_axi_wdata;
                w_last[w_n] = m_axi_wlast;
                w_cyc[w_n]  = cyc;
                if (m_axi_wstrb !== 4'hF) attr_bad = attr_bad + 1;
                w_n = w_n + 1;
                pop_total = pop_total + 1;
            end
            if (req_total - pop_total > max_pend) max_pend = req_total - pop_total;
            if (m_axi_bvalid && m_axi_bready) begin
                b_count = b_count + 1;
                b_cyc   = cyc;
            end
            if (o_write_done) begin
                done_cnt    = done_cnt + 1;
                done_cyc    = cyc;
                err_at_done = o_err;
            end
            if (m_axi_awvalid || m_axi_wvalid) any_activity = any_activity + 1;
        end
    end

    // driver tasks
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int start_cyc;

    task automatic start(input logic [31:0] addr, input logic [17:0] n);
        i_ctrl_write = 1'b1;
        i_write_addr = addr;
        i_num_trans  = n;
        start_cyc    = cyc;
        tick();
        i_ctrl_write = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {o_indata_req_wr, o_write_done, o_busy, o_err, m_axi_awvalid,
                            m_axi_wvalid, m_axi_wlast, m_axi_bready}, 64'd0);
        chk({tag, "_aw"}, {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst}, 64'd0);
        chk({tag, "_w"}, {m_axi_wdata, m_axi_wstrb}, 64'd0);
    endtask

    // Scoreboard: the buffer hands out consecutive words, so beat k must carry word base+k.
    task automatic check_beats(input string tag, input int base, input int n, input int wb);
        logic [31:0] e;
        chk({tag, "_nbeats"}, 64'(w_n - wb), 64'(n));
        for (int k = 0; k < n; k++) exp_q.push_back(32'hA000_0000 + 32'(base + k));
        for (int k = 0; k < n && (wb + k) < 512; k++) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, w_data[wb + k], e);
            chk({tag, "_last"}, w_last[wb + k], ((k % 16) == 15) || (k == n - 1));
        end
        exp_q.delete();
    endtask

    task automatic check_aws(input string tag, input int ab, input logic [31:0] addr, input int n);
        int nb = (n + 15) / 16;
        chk({tag, "_naw"}, 64'(aw_n - ab), 64'(nb));
        for (int i = 0; i < nb && (ab + i) < 64; i++) begin
            chk({tag, "_awaddr"}, aw_addr_a[ab + i], addr + 32'(i * 64));
            chk({tag, "_awlen"}, aw_len_a[ab + i], (i < nb - 1) ? 8'd15 : 8'((n - 1) % 16));
        end
    endtask

    int base, wb, ab, d0, act0, k;

    initial begin
        rst = 1'b1; i_ctrl_write = 1'b0; i_write_addr = '0; i_num_trans = '0;
        wready_rand = 1'b0; aw_delay = 0; berr_at = -1;
        n_checks = 0; n_errors = 0;
        repeat (3) tick();
        chk_zero("por");
        rst = 1'b0;
        tick();

        // single 16-beat burst, everything ready
        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h1000_0000, 18'd16);
        chk("t1_awvalid_c1", m_axi_awvalid, 1);
        chk("t1_req_c1", o_indata_req_wr, 1);
        chk("t1_wvalid_c1", m_axi_wvalid, 0);
        chk("t1_busy_c1", o_busy, 1);
        wait_done(d0, 200, "t1_done");
        chk("t1_done_cycle", 64'(done_cyc - start_cyc), 64'd20);
        chk("t1_done_after_b", 64'(done_cyc - b_cyc), 64'd1);
        check_aws("t1", ab, 32'h1000_0000, 16);
        check_beats("t1", base, 16, wb);
        chk("t1_back_to_back", 64'(w_cyc[wb + 15] - w_cyc[wb]), 64'd15);
        repeat (3) tick();
        chk("t1_one_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_idle", o_busy, 0);

        // 40 beats -> 16 + 16 + 8
        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h2000_0000, 18'd40);
        wait_done(d0, 400, "t2_done");
        check_aws("t2", ab, 32'h2000_0000, 40);
        check_beats("t2", base, 40, wb);
        chk("t2_err", err_at_done, 0);
        repeat (3) tick();
        chk("t2_one_done", 64'(done_cnt - d0), 64'd1);

        // random wready, slow awready
        wready_rand = 1'b1; aw_delay = 5;
        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h3000_0000, 18'd40);
        wait_done(d0, 2000, "t3_done");
        check_aws("t3", ab, 32'h3000_0000, 40);
        check_beats("t3", base, 40, wb);
        chk("t3_aw_stable", 64'(aw_unstable), 64'd0);
        chk("t3_max_pending_le2", 64'(max_pend <= 2), 64'd1);
        wready_rand = 1'b0; aw_delay = 0;

        // error response on the second of three bursts
        berr_at = b_count + 1;
        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h4000_0000, 18'd40);
        wait_done(d0, 400, "t4_done");
        chk("t4_err_at_done", err_at_done, 1);
        check_beats("t4", base, 40, wb);
        tick();
        chk("t4_err_sticky", o_err, 1);
        berr_at = -1;

        // empty request: done at cycle 2, no AXI traffic, error cleared
        wb = w_n; ab = aw_n; d0 = done_cnt; act0 = any_activity;
        start(32'h5000_0000, 18'd0);
        chk("t5_err_cleared", o_err, 0);
        chk("t5_c1_ctl", {m_axi_awvalid, m_axi_wvalid, o_write_done, o_busy}, 4'b0001);
        tick();
        chk("t5_c2_done", o_write_done, 1);
        tick();
        chk("t5_c3_ctl", {o_write_done, o_busy}, 2'b00);
        chk("t5_no_axi", 64'(any_activity - act0 + aw_n - ab + w_n - wb), 64'd0);
        chk("t5_one_done", 64'(done_cnt - d0), 64'd1);

        // second start pulse mid-transfer is ignored
        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h6000_0000, 18'd16);
        repeat (5) tick();
        i_ctrl_write = 1'b1; i_write_addr = 32'h7000_0000; i_num_trans = 18'd3;
        tick();
        i_ctrl_write = 1'b0;
        wait_done(d0, 200, "t6_done");
        repeat (4) tick();
        check_aws("t6", ab, 32'h6000_0000, 16);
        check_beats("t6", base, 16, wb);
        chk("t6_one_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_idle", o_busy, 0);

        // reset while beat 5 is on the bus
        wb = w_n; d0 = done_cnt;
        start(32'h8000_0000, 18'd16);
        k = 0;
        while (w_n - wb < 5 && k < 100) begin
            tick();
            k++;
        end
        chk("t7_reach_beat5", 64'(w_n - wb), 64'd5);
        rst = 1'b1;
        tick();
        chk_zero("t7_rst");
        rst = 1'b0;
        repeat (3) tick();
        chk("t7_no_done", 64'(done_cnt - d0), 64'd0);

        base = rd_idx; wb = w_n; ab = aw_n; d0 = done_cnt;
        start(32'h9000_0000, 18'd16);
        wait_done(d0, 200, "t7_done");
        chk("t7_done_cycle", 64'(done_cyc - start_cyc), 64'd20);
        check_aws("t7", ab, 32'h9000_0000, 16);
        check_beats("t7", base, 16, wb);
        chk("attr_ok", 64'(attr_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
